// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] DATA_OFS   = 8'h00;
    localparam logic [7:0] STATUS_OFS = 8'h04;

    localparam int STAT_OVERFLOW_BIT = 8;
    localparam int STAT_PARITY_BIT   = 9;
    localparam int STAT_FRAME_BIT    = 10;
    localparam int STAT_TIMEOUT_BIT  = 11;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    // Odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] code, input logic par);
        return (^code) ^ par;
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Pin synchronisers, ps2_clk glitch filter and falling-edge sample strobe.
module ps2_sync_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall_strobe,
    output logic data_s
);

    localparam int FW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    data_sync_q, data_sync_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          strobe_q, strobe_d;

    // Filter: the accepted level flips after FILTER_LEN consecutive differing samples.
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        filt_d      = filt_q;
        fcnt_d      = '0;
        strobe_d    = 1'b0;
        if (clk_sync_q[1] != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d   = clk_sync_q[1];
                strobe_d = filt_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end else begin
            fcnt_d = '0;
        end
    end

    // State registers; synchronisers idle high like the open-collector bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            fcnt_q      <= '0;
            strobe_q    <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            strobe_q    <= strobe_d;
        end
    end

    assign fall_strobe = strobe_q;
    assign data_s      = data_sync_q[1];

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 frame receiver with scancode FIFO and polled register window.
// Define PS2_BREAK_DECODE_EN to fold F0/E0 prefixes into brk/ext entry bits.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        mem_read,
    input  logic [7:0]  mem_addr,
    output logic [31:0] mem_rdata
);

`ifdef PS2_BREAK_DECODE_EN
    localparam int EW = 10;
`else
    localparam int EW = 8;
`endif
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] DATA_SEL   = DATA_OFS[3:2];
    localparam logic [1:0] STATUS_SEL = STATUS_OFS[3:2];

    logic          strobe_s, data_s;
    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          frame_ok_s, set_perr_s, set_ferr_s, set_to_s;
    logic          push_req_s, push_ok_s, pop_s, clr_s, full_s, rd_rise_s;
    logic [EW-1:0] push_data_s, head_s;
    logic [EW-1:0] fifo_q [DEPTH];
    logic [EW-1:0] fifo_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d, toerr_q, toerr_d;
    logic          rd_q, rd_d;
    logic [1:0]    sel_s;
    logic [31:0]   status_s;
    logic          addr_unused_s;

    assign addr_unused_s = ^{mem_addr[7:4], mem_addr[1:0]};

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync (
        .clk         (clk),
        .reset_n     (reset_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .fall_strobe (strobe_s),
        .data_s      (data_s)
    );

    // Frame FSM; the timeout counter measures idle cycles since the last strobe.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        to_cnt_d   = '0;
        frame_ok_s = 1'b0;
        set_perr_s = 1'b0;
        set_ferr_s = 1'b0;
        set_to_s   = 1'b0;
        if (strobe_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (!data_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_d = {data_s, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    par_d   = data_s;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    frame_ok_s = data_s & odd_parity_ok(shift_q, par_q);
                    set_perr_s = ~odd_parity_ok(shift_q, par_q);
                    set_ferr_s = ~data_s;
                    state_d    = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d  = ST_IDLE;
                set_to_s = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end else begin
            to_cnt_d = '0;
        end
    end

`ifdef PS2_BREAK_DECODE_EN
    logic brk_pend_q, brk_pend_d, ext_pend_q, ext_pend_d;

    // Prefix bytes only arm the pending bits; the next real code carries them.
    always_comb begin
        push_req_s  = frame_ok_s;
        push_data_s = EW'(shift_q);
        brk_pend_d  = brk_pend_q;
        ext_pend_d  = ext_pend_q;
        if (frame_ok_s) begin
            if (shift_q == PS2_BREAK) begin
                brk_pend_d = 1'b1;
                push_req_s = 1'b0;
            end else if (shift_q == PS2_EXT) begin
                ext_pend_d = 1'b1;
                push_req_s = 1'b0;
            end else begin
                push_data_s = {ext_pend_q, brk_pend_q, shift_q};
                brk_pend_d  = 1'b0;
                ext_pend_d  = 1'b0;
            end
        end else begin
            push_req_s = 1'b0;
        end
    end

    // Pending prefix registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            brk_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
        end else begin
            brk_pend_q <= brk_pend_d;
            ext_pend_q <= ext_pend_d;
        end
    end
`else
    // Raw mode: every good byte is queued unchanged.
    always_comb begin
        push_req_s  = frame_ok_s;
        push_data_s = EW'(shift_q);
    end
`endif

    // FIFO and sticky flags; a pop in the same cycle makes room for the push.
    always_comb begin
        sel_s     = mem_addr[3:2];
        rd_d      = mem_read;
        rd_rise_s = mem_read & ~rd_q;
        full_s    = (count_q == CW'(DEPTH));
        pop_s     = rd_rise_s & (sel_s == DATA_SEL) & (count_q != '0);
        clr_s     = rd_rise_s & (sel_s == STATUS_SEL);
        push_ok_s = push_req_s & (~full_s | pop_s);
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push_ok_s) begin
            fifo_d[wr_ptr_q] = push_data_s;
            wr_ptr_d         = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d   = (push_req_s & full_s & ~pop_s) | (ovf_q & ~clr_s);
        perr_d  = set_perr_s | (perr_q & ~clr_s);
        ferr_d  = set_ferr_s | (ferr_q & ~clr_s);
        toerr_d = set_to_s | (toerr_q & ~clr_s);
    end

    // Read data is a pure function of address and current state.
    always_comb begin
        head_s                     = fifo_q[rd_ptr_q];
        status_s                   = 32'd0;
        status_s[6:0]              = 7'(count_q);
        status_s[STAT_OVERFLOW_BIT] = ovf_q;
        status_s[STAT_PARITY_BIT]  = perr_q;
        status_s[STAT_FRAME_BIT]   = ferr_q;
        status_s[STAT_TIMEOUT_BIT] = toerr_q;
        case (sel_s)
            DATA_SEL: begin
                if (count_q != '0) begin
                    mem_rdata = {1'b1, 21'd0, 10'(head_s)};
                end else begin
                    mem_rdata = 32'd0;
                end
            end
            STATUS_SEL: mem_rdata = status_s;
            default:    mem_rdata = 32'd0;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
            fifo_q    <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            toerr_q   <= 1'b0;
            rd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            to_cnt_q  <= to_cnt_d;
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            toerr_q   <= toerr_d;
            rd_q      <= rd_d;
        end
    end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
PS/2 device-to-host receiver with a scancode FIFO and a memory-mapped read port. Sits between the ps2_clk/ps2_data pins and the memory controller's keyboard window (kb_read/kb_addr/kb_rdata), in the clk_100 domain.
Deserialises 11-bit PS/2 frames, checks them, and buffers good codes until the CPU polls them.

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..64
FILTER_LEN, 8, consecutive stable samples required before a synchronised ps2_clk level is accepted
TIMEOUT_CYCLES, 200000, idle clk cycles inside a frame before abort (2 ms at 100 MHz)

Ports:
clk  in  1  system clock, clk_100
reset_n  in  1  asynchronous active-low reset
ps2_clk  in  1  raw PS/2 clock pin (asynchronous)
ps2_data  in  1  raw PS/2 data pin (asynchronous)
mem_read  in  1  read strobe from memory controller (level)
mem_addr  in  8  byte offset within keyboard window
mem_rdata  out  32  read data, combinational from mem_addr and state

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE, FIFO empty, sticky flags 0, filter/timeout counters 0, synchronisers preset to 1. mem_rdata=0 while the FIFO is empty.
- Input conditioning:
  - 2-FF synchroniser on each pin.
  - The filtered ps2_clk level changes only after FILTER_LEN identical consecutive samples.
  - A falling edge of the filtered clock is a one-cycle sample strobe; ps2_data (synchronised) is sampled on that strobe.
- Frame FSM (states IDLE, DATA, PARITY, STOP):
  - IDLE: a strobe with data=0 goes to DATA with bit count 0. A strobe with data=1 stays in IDLE and is ignored.
  - DATA: shift in LSB first. After the 8th bit, go to PARITY.
  - PARITY: record the bit. Odd parity is required (data ones + parity bit must be odd). Go to STOP.
  - STOP: if data=1 and parity is good, push the code. Parity bad: set parity_err, no push. Stop bit=0: set frame_err, no push. Always return to IDLE.
  - Timeout: the counter resets on every strobe and in IDLE. Reaching TIMEOUT_CYCLES in a non-IDLE state forces IDLE and sets timeout_err. The partial byte is discarded.
- FIFO:
  - Push occurs in the STOP-state cycle.
  - Full with no pop in the same cycle: the code is dropped and the overflow flag is set.
  - Pop and push in the same cycle: pop applies first, so a full FIFO accepts the push and overflow is not set.
  - Count width is clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Register map (decode mem_addr[3:2]):
  - 0x00 DATA = {valid[31], 21'b0, ext[9], brk[8], code[7:0]}, read from the FIFO head.
    - Empty: returns 0 and does not pop.
    - Pop happens on the first cycle mem_read is high, i.e. mem_read=1 and its registered value was 0. One access equals one pop, even if mem_read is held.
  - 0x04 STATUS = {20'b0, timeout_err[11], frame_err[10], parity_err[9], overflow[8], 1'b0..., count[6:0]}.
    - A rising-edge read clears bits [11:8] after the value is returned.
    - If a flag is set and cleared in the same cycle, set wins.
  - Other offsets read 0 and have no side effects. mem_rdata is valid whether or not mem_read is asserted. Only popping and flag clearing need the strobe.
- Latency: a code becomes readable on the cycle after the STOP strobe.

Optional Feature:
PS2_BREAK_DECODE_EN
- Defined:
  - 0xF0 sets an internal brk_pending and 0xE0 sets ext_pending; neither prefix is pushed.
  - The next non-prefix code is pushed with brk/ext equal to the pending bits, and both pending bits then clear.
  - A frame error or timeout does not clear the pending bits.
  - FIFO width is 10 bits.
- Undefined: every good byte is pushed raw, including F0 and E0. Bits [9:8] read 0 and the FIFO width is 8.

Decomposition:
- Package ps2_pkg holds:
  - the FSM state enum;
  - register offsets DATA_OFS=0x00 and STATUS_OFS=0x04;
  - STATUS bit positions;
  - constants PS2_BREAK=8'hF0 and PS2_EXT=8'hE0.
- Sub-module ps2_sync_filter holds the synchroniser, the FILTER_LEN glitch filter and the falling-edge strobe, and outputs fall_strobe and data_s. The FIFO and FSM stay in the top-level module.

Test Plan:
- Good frame: send 0x1C (start 0; data 0,0,1,1,1,0,0,0; parity 0; stop 1) at 12.5 kHz -> STATUS count=1. DATA read returns 0x8000001C, then the next DATA read returns 0x00000000 with count=0.
- Parity error: send 0x1C with parity=1 -> count stays 0 and STATUS[9]=1. A second STATUS read returns bit 9 as 0.
- Overflow and ordering: DEPTH=16; send codes 0x01..0x11 (17 frames) -> count=16 and overflow=1. Sixteen DATA reads return 0x01..0x10 in order. A code pushed in the same cycle as a pop on a full FIFO is kept.
- Timeout and glitch:
  - Send start plus 4 bits, then hold ps2_clk high for 2.1 ms -> timeout_err=1 and FSM in IDLE. A following 0x2A frame is received intact.
  - A 3-cycle low glitch on ps2_clk produces no strobe and no state change.
- Break decode: send F0 then 1C.
  - Macro defined: a single entry 0x8000011C.
  - Macro undefined: entries 0x800000F0 then 0x8000001C.
- Reset and held read:
  - Assert reset_n=0 mid-frame after 5 bits -> FIFO empty and flags 0. The next full frame is decoded correctly.
  - Holding mem_read high for 10 cycles at DATA pops exactly one entry.
